load_store_unit: RTL and testbench

Initiator side of the data-cache access interface. Accepts load/store requests from the execute stage over a valid/ready handshake and drives the cache port (active-low write strobe, 3-bit width code, address, write data). Returns sign/zero-extended load data. Optionally splits misaligned halfword/word accesses into sequential byte accesses. Sits between the execute stage and the data cache in the memory stage.

---
 rtl/load_store_unit.sv | 198 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-cache port.
// Accepts one load/store at a time from the execute stage, drives the cache
// port, and returns sign/zero-extended load data. Misaligned halfword/word
// accesses are either split into sequential byte accesses or rejected.
//
// Request handshake: a request transfers on a rising edge where both
// req_valid and req_ready are 1. req_ready is high only while idle. A
// request held during a busy period is ignored until the unit is idle
// again. The response is a one-cycle resp_valid strobe with no
// backpressure.
module load_store_unit #(
   parameter int ADDR_WIDTH       = 32,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic                  dcache_write_en,
   output logic [2:0]            dcache_width,
   output logic [ADDR_WIDTH-1:0] dcache_address,
   output logic [31:0]           dcache_wdata,
   input  logic [31:0]           dcache_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_SPLIT  = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  write_q, write_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           result_q, result_d;
   logic                  error_q, error_d;
   logic                  split_q, split_d;
   logic [1:0]            index_q, index_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

   logic                  bad_funct3;
   logic                  misaligned;
   logic [1:0]            split_last;
   logic [7:0]            store_byte;

   // Request classification: illegal encodings and alignment of the new request.
   always_comb begin
      bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]);
      misaligned = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
      split_last = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
      case (index_q)
         2'd0:    store_byte = wdata_q[7:0];
         2'd1:    store_byte = wdata_q[15:8];
         2'd2:    store_byte = wdata_q[23:16];
         default: store_byte = wdata_q[31:24];
      endcase
   end

   // Cache port drive; the address holds its last value outside of accesses.
   always_comb begin
      dcache_write_en = 1'b1;
      dcache_width    = 3'b000;
      dcache_wdata    = 32'd0;
      dcache_address  = last_addr_q;
      if (state_q == S_ACCESS) begin
         dcache_width   = funct3_q;
         dcache_address = addr_q;
         if (write_q) begin
            dcache_write_en = 1'b0;
            dcache_wdata    = wdata_q;
         end
      end else if (state_q == S_SPLIT) begin
         dcache_address = addr_q + ADDR_WIDTH'(index_q);
         if (write_q) begin
            dcache_write_en = 1'b0;
            dcache_width    = 3'b000;
            dcache_wdata    = {24'd0, store_byte};
         end else begin
            dcache_width = 3'b100;
         end
      end
      last_addr_d = dcache_address;
   end

   // Response drive; split loads are extended here, aligned loads pass as returned.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_error = (state_q == S_RESP) && error_q;
      resp_rdata = 32'd0;
      if ((state_q == S_RESP) && !error_q && !write_q) begin
         if (split_q) begin
            case (funct3_q)
               3'b001:  resp_rdata = {{16{result_q[15]}}, result_q[15:0]};
               3'b101:  resp_rdata = {16'd0, result_q[15:0]};
               default: resp_rdata = result_q;
            endcase
         end else begin
            resp_rdata = result_q;
         end
      end
   end

   // Next-state logic: request capture, access sequencing and result assembly.
   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      result_d = result_q;
      error_d  = error_q;
      split_d  = split_q;
      index_d  = index_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_address;
               wdata_d  = req_wdata;
               result_d = 32'd0;
               index_d  = 2'd0;
               error_d  = 1'b0;
               split_d  = 1'b0;
               if (bad_funct3 || (misaligned && !SPLIT_MISALIGNED)) begin
                  error_d = 1'b1;
                  state_d = S_RESP;
               end else if (misaligned) begin
                  split_d = 1'b1;
                  state_d = S_SPLIT;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            if (!write_q) result_d = dcache_rdata;
            state_d = S_RESP;
         end
         S_SPLIT: begin
            if (!write_q) begin
               case (index_q)
                  2'd0:    result_d[7:0]   = dcache_rdata[7:0];
                  2'd1:    result_d[15:8]  = dcache_rdata[7:0];
                  2'd2:    result_d[23:16] = dcache_rdata[7:0];
                  default: result_d[31:24] = dcache_rdata[7:0];
               endcase
            end
            if (index_q == split_last) begin
               index_d = 2'd0;
               state_d = S_RESP;
            end else begin
               index_d = index_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         result_q    <= 32'd0;
         error_q     <= 1'b0;
         split_q     <= 1'b0;
         index_q     <= 2'd0;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         result_q    <= result_d;
         error_q     <= error_d;
         split_q     <= split_d;
         index_q     <= index_d;
         last_addr_q <= last_addr_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-addressed cache model (256 bytes, low
// address bits) feeds the unit, and a reference model computes response
// data, latency, strobe count and the access pattern of every request.
// A second instance with splitting disabled shares the request inputs.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_address = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        dcache_write_en;
   logic [2:0]  dcache_width;
   logic [31:0] dcache_address;
   logic [31:0] dcache_wdata;
   logic [31:0] dcache_rdata;

   logic        ns_req_ready;
   logic        ns_resp_valid;
   logic [31:0] ns_resp_rdata;
   logic        ns_resp_error;
   logic        ns_dcache_write_en;
   logic [2:0]  ns_dcache_width;
   logic [31:0] ns_dcache_address;
   logic [31:0] ns_dcache_wdata;
   logic [31:0] ns_dcache_rdata = 32'd0;

   int total = 0;
   int bad = 0;
   logic [31:0] exp_q[$];

   logic [7:0] mem [0:255];
   logic [7:0] ref_mem [0:255];
   logic       pre_we = 1'b0;
   logic [7:0] pre_a = 8'd0;
   logic [7:0] pre_d = 8'd0;
   logic [7:0] ca0, ca1, ca2, ca3;
   logic [31:0] raw;

   load_store_unit #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .dcache_write_en(dcache_write_en),
      .dcache_width(dcache_width), .dcache_address(dcache_address),
      .dcache_wdata(dcache_wdata), .dcache_rdata(dcache_rdata)
   );

   load_store_unit #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ns_req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address),
      .req_wdata(req_wdata), .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata),
      .resp_error(ns_resp_error), .dcache_write_en(ns_dcache_write_en),
      .dcache_width(ns_dcache_width), .dcache_address(ns_dcache_address),
      .dcache_wdata(ns_dcache_wdata), .dcache_rdata(ns_dcache_rdata)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         3'b000:  return {{24{v[7]}}, v[7:0]};
         3'b001:  return {{16{v[15]}}, v[15:0]};
         3'b100:  return {24'd0, v[7:0]};
         3'b101:  return {16'd0, v[15:0]};
         default: return v;
      endcase
   endfunction

   // cache model: combinational read, write on rising edge with active-low strobe
   assign ca0 = dcache_address[7:0];
   assign ca1 = ca0 + 8'd1;
   assign ca2 = ca0 + 8'd2;
   assign ca3 = ca0 + 8'd3;
   always_comb begin
      raw = {mem[ca3], mem[ca2], mem[ca1], mem[ca0]};
      dcache_rdata = extend(dcache_width, raw);
   end
   always @(posedge clk) begin
      if (pre_we) mem[pre_a] <= pre_d;
      if (!dcache_write_en) begin
         mem[ca0] <= dcache_wdata[7:0];
         if (dcache_width[1:0] != 2'b00) mem[ca1] <= dcache_wdata[15:8];
         if (dcache_width[1:0] == 2'b10) begin
            mem[ca2] <= dcache_wdata[23:16];
            mem[ca3] <= dcache_wdata[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_a = a; pre_d = d;
      @(posedge clk);
      #1 pre_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_rerr"}, 32'(resp_error), 32'd0);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_we"}, 32'(dcache_write_en), 32'd1);
      chk({tag, "_width"}, 32'(dcache_width), 32'd0);
      chk({tag, "_addr"}, dcache_address, 32'd0);
      chk({tag, "_wdata"}, dcache_wdata, 32'd0);
   endtask

   // one request through both instances, checked against the reference model
   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic hold);
      int sz, n, exp_lat, exp_str, ns_exp_lat, got_lat, ns_lat, strobes;
      logic err, ns_err, mis, got_err, got_ns_err;
      logic [31:0] exp_rd, got_rd, v;
      logic [31:0] c_addr [1:8];
      logic [2:0]  c_w [1:8];
      logic [31:0] c_wd [1:8];
      sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
      mis = !err && ((addr % sz) != 0);
      ns_err = err || mis;
      v = 32'd0;
      for (int i = 0; i < sz; i++) v[i*8 +: 8] = ref_mem[8'(addr + 32'(i))];
      exp_rd = (err || wr) ? 32'd0 : extend(f3, v);
      exp_lat = err ? 1 : mis ? 1 + sz : 2;
      ns_exp_lat = ns_err ? 1 : 2;
      exp_str = (err || !wr) ? 0 : mis ? sz : 1;
      exp_q.push_back(exp_rd);
      if (mis) hold = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_wdata = wd;
      chk("ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      if (hold) begin
         req_write = ~wr; req_funct3 = 3'b010; req_address = ~addr; req_wdata = ~wd;
      end else begin
         req_valid = 1'b0;
      end
      got_lat = 0; ns_lat = 0; strobes = 0; got_rd = 32'd0; got_err = 1'b0; got_ns_err = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         c_addr[c] = dcache_address; c_w[c] = dcache_width; c_wd[c] = dcache_wdata;
         if (!dcache_write_en) strobes++;
         if (c == 1) chk("busy_ready", 32'(req_ready), 32'd0);
         if (ns_resp_valid && ns_lat == 0) begin
            ns_lat = c; got_ns_err = ns_resp_error;
         end
         if (resp_valid) begin
            got_lat = c; got_rd = resp_rdata; got_err = resp_error;
            req_valid = 1'b0;
            break;
         end
      end
      req_valid = 1'b0;
      exp_rd = exp_q.pop_front();
      if (got_lat == 0) begin
         chk("timeout", 32'd0, 32'd1);
      end else begin
         chk("latency", 32'(got_lat), 32'(exp_lat));
         chk("rdata", got_rd, exp_rd);
         chk("error", 32'(got_err), 32'(err));
         chk("strobes", 32'(strobes), 32'(exp_str));
         chk("ns_latency", 32'(ns_lat), 32'(ns_exp_lat));
         chk("ns_error", 32'(got_ns_err), 32'(ns_err));
         if (!err) begin
            n = mis ? sz : 1;
            for (int i = 0; i < n; i++) begin
               chk("acc_addr", c_addr[i+1], addr + 32'(i));
               chk("acc_width", 32'(c_w[i+1]), mis ? (wr ? 32'd0 : 32'd4) : 32'(f3));
               if (wr) chk("acc_wdata", c_wd[i+1], mis ? {24'd0, wd[i*8 +: 8]} : wd);
            end
         end
      end
      if (wr && !err)
         for (int i = 0; i < sz; i++) ref_mem[8'(addr + 32'(i))] = wd[i*8 +: 8];
   endtask

   initial begin
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
      preload(8'h10, 8'hEF); preload(8'h11, 8'hBE); preload(8'h12, 8'hAD); preload(8'h13, 8'hDE);
      preload(8'h03, 8'h80); preload(8'h04, 8'hFF);

      // directed cases
      do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b0);
      do_req(1'b1, 3'b000, 32'h0000_0005, 32'h1234_5678, 1'b0);
      do_req(1'b0, 3'b001, 32'h0000_0003, 32'd0, 1'b0);
      do_req(1'b0, 3'b101, 32'h0000_0003, 32'd0, 1'b0);
      do_req(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1'b0);
      do_req(1'b0, 3'b011, 32'h0000_0010, 32'd0, 1'b0);
      do_req(1'b1, 3'b100, 32'h0000_0008, 32'h5555_5555, 1'b0);
      do_req(1'b0, 3'b010, 32'h0000_0002, 32'd0, 1'b0);
      do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0, 1'b1);
      chk("sb_byte", 32'(mem[8'h05]), 32'h78);
      chk("sw_wrap_byte", 32'(mem[8'h01]), 32'hA1);

      // reset during the second split cycle of a store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_address = 32'h0000_0021; req_wdata = 32'h1122_3344;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rst_split0_we", 32'(dcache_write_en), 32'd0);
      @(negedge clk);
      chk("rst_split1_addr", dcache_address, 32'h0000_0022);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("midrst_noresp", 32'(resp_valid), 32'd0);
      end
      rst = 1'b0;
      ref_mem[8'h21] = 8'h44;
      chk("midrst_byte0", 32'(mem[8'h21]), 32'h44);

      // randomized traffic
      for (int k = 0; k < 80; k++) begin
         logic [31:0] a;
         a = $urandom();
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
